// File: rtl/mac_hakemi_pkg.sv
// Shared encodings for the match referee: FSM states, winner codes and the
// largest score a single round can award.
package mac_hakemi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLAY   = 2'd1,
        ST_SUDDEN = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [1:0] W_NONE = 2'b00;
    localparam logic [1:0] W_P1   = 2'b01;
    localparam logic [1:0] W_P2   = 2'b10;

    localparam int MAX_PTS = 3;

endpackage

// File: rtl/doygun_toplayici.sv
// Saturating running-total register with synchronous clear and enable.
// The combinational next value is exported so the referee can decide on it.
module doygun_toplayici #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [1:0]   pts,
    output logic [W-1:0] total,
    output logic [W-1:0] total_next
);

    logic [W-1:0] total_reg;
    logic [W:0]   sum_wide;

    assign sum_wide   = {1'b0, total_reg} + {{(W-1){1'b0}}, pts};
    // Carry out of the top bit means the total would wrap: clamp instead.
    assign total_next = sum_wide[W] ? {W{1'b1}} : sum_wide[W-1:0];
    assign total      = total_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_reg <= '0;
        end else if (clr) begin
            total_reg <= '0;
        end else if (en) begin
            total_reg <= total_next;
        end
    end

endmodule

// File: rtl/mac_hakemi.sv
// Match referee: accumulates per-round points, ends the match once the lead
// cannot be overturned, and runs sudden-death rounds after a regular-time tie.
module mac_hakemi
    import mac_hakemi_pkg::*;
#(
    parameter int ROUNDS  = 5,
    parameter int SCORE_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               round_valid,
    input  logic [1:0]         p1_pts,
    input  logic [1:0]         p2_pts,
    output logic               round_ready,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [7:0]         round_cnt,
    output logic               sudden,
    output logic               done,
    output logic [1:0]         winner
);

    state_t       state_reg;
    logic         ready_reg;
    logic         sudden_reg;
    logic         done_reg;
    logic [1:0]   winner_reg;
    logic [7:0]   cnt_reg;

    logic               accept;
    logic [SCORE_W-1:0] s1_next;
    logic [SCORE_W-1:0] s2_next;
    logic               p1_ahead;
    logic [SCORE_W-1:0] margin;
    logic [7:0]         thr;
    logic               lead_safe;
    logic               last_round;
    logic [7:0]         cnt_inc;

    // A simultaneous start wins, so the round on that edge is thrown away.
    assign accept = round_valid & ready_reg & ~start;

    doygun_toplayici #(.W(SCORE_W)) u_score1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (start),
        .en         (accept),
        .pts        (p1_pts),
        .total      (score1),
        .total_next (s1_next)
    );

    doygun_toplayici #(.W(SCORE_W)) u_score2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (start),
        .en         (accept),
        .pts        (p2_pts),
        .total      (score2),
        .total_next (s2_next)
    );

    // Points still available to the trailing player after round k = index+1.
    logic [7:0] thr_tab [16];
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_thr
            if (gi < ROUNDS) begin : g_live
                assign thr_tab[gi] = 8'(MAX_PTS * (ROUNDS - 1 - gi));
            end else begin : g_dead
                assign thr_tab[gi] = 8'd0;
            end
        end
    endgenerate

    // In PLAY the count never exceeds ROUNDS-1 (<= 14), so 4 index bits suffice.
    assign thr        = thr_tab[cnt_reg[3:0]];
    assign p1_ahead   = s1_next > s2_next;
    assign margin     = p1_ahead ? (s1_next - s2_next) : (s2_next - s1_next);
    assign lead_safe  = 16'(margin) > 16'(thr);
    assign last_round = cnt_reg == 8'(ROUNDS - 1);
    assign cnt_inc    = (cnt_reg == 8'hFF) ? cnt_reg : cnt_reg + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            ready_reg  <= 1'b0;
            sudden_reg <= 1'b0;
            done_reg   <= 1'b0;
            winner_reg <= W_NONE;
            cnt_reg    <= 8'd0;
        end else if (start) begin
            state_reg  <= ST_PLAY;
            ready_reg  <= 1'b1;
            sudden_reg <= 1'b0;
            done_reg   <= 1'b0;
            winner_reg <= W_NONE;
            cnt_reg    <= 8'd0;
        end else begin
            case (state_reg)
                ST_PLAY: begin
                    if (accept) begin
                        cnt_reg <= cnt_inc;
                        if (lead_safe) begin
                            state_reg  <= ST_DONE;
                            ready_reg  <= 1'b0;
                            done_reg   <= 1'b1;
                            winner_reg <= p1_ahead ? W_P1 : W_P2;
                        end else if (last_round && (s1_next == s2_next)) begin
                            state_reg  <= ST_SUDDEN;
                            sudden_reg <= 1'b1;
                        end
                    end
                end
                ST_SUDDEN: begin
                    if (accept) begin
                        cnt_reg <= cnt_inc;
                        // Decide on the round's points: totals may both be saturated.
                        if (p1_pts != p2_pts) begin
                            state_reg  <= ST_DONE;
                            ready_reg  <= 1'b0;
                            done_reg   <= 1'b1;
                            winner_reg <= (p1_pts > p2_pts) ? W_P1 : W_P2;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign round_ready = ready_reg;
    assign sudden      = sudden_reg;
    assign done        = done_reg;
    assign winner      = winner_reg;
    assign round_cnt   = cnt_reg;

endmodule
